// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and width helpers for the game sequencer
package game_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      START       = 3'd1,
      PLAYING     = 3'd2,
      PAUSED      = 3'd3,
      LIFE_LOST   = 3'd4,
      LEVEL_CLEAR = 3'd5,
      GAME_OVER   = 3'd6
   } game_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int lives_w(input int num_lives);
      return $clog2(num_lives + 1);
   endfunction

   // A single wave still needs a 1-bit level port.
   function automatic int level_w(input int num_levels);
      return (num_levels <= 1) ? 1 : $clog2(num_levels);
   endfunction

   function automatic int cnt_w(input int respawn_cycles, input int clear_cycles);
      return $clog2(max_int(respawn_cycles, clear_cycles) + 1);
   endfunction

endpackage

// File: rtl/game_ctrl_fsm_edge_detect.sv
// rtl/game_ctrl_fsm_edge_detect.sv - registered rising-edge detector for button levels
module edge_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] edge_o
);

   logic [W-1:0] d_q;

   // Loading the live level on reset keeps a held button from firing an edge.
   always_ff @(posedge clk) begin
      d_q <= d_i;
   end

   assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// rtl/game_ctrl_fsm.sv - game sequencer: lives, waves, pause, timed respawn and intermissions
module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int NUM_LIVES      = 3,
   parameter int NUM_LEVELS     = 4,
   parameter int RESPAWN_CYCLES = 50_000_000,
   parameter int CLEAR_CYCLES   = 100_000_000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_btn,
   input  logic                             pause_btn,
   input  logic                             player_hit,
   input  logic                             wave_cleared,
   input  logic                             invaders_landed,
   output game_state_t                      state_o,
   output logic                             start_pulse,
   output logic                             level_start,
   output logic                             is_playing,
   output logic                             is_paused,
   output logic                             is_finished,
   output logic                             won,
   output logic [lives_w(NUM_LIVES)-1:0]    lives,
   output logic [level_w(NUM_LEVELS)-1:0]   level
);

   localparam int LIVES_W = lives_w(NUM_LIVES);
   localparam int LEVEL_W = level_w(NUM_LEVELS);
   localparam int CNT_W   = cnt_w(RESPAWN_CYCLES, CLEAR_CYCLES);

   localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
   localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_LAST   = LEVEL_W'(NUM_LEVELS - 1);
   localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);

   logic start_e;
   logic pause_e;

   edge_detect #(.W(1)) u_start_edge (
      .clk    (clk),
      .reset  (reset),
      .d_i    (start_btn),
      .edge_o (start_e)
   );

   edge_detect #(.W(1)) u_pause_edge (
      .clk    (clk),
      .reset  (reset),
      .d_i    (pause_btn),
      .edge_o (pause_e)
   );

   game_state_t        state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               won_q, won_d;
   logic               start_pulse_q, start_pulse_d;
   logic               level_start_q, level_start_d;
   logic               is_playing_q, is_paused_q, is_finished_q;

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      level_d       = level_q;
      won_d         = won_q;
      start_pulse_d = 1'b0;
      level_start_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_e) state_d = START;
         end
         START: begin
            state_d = PLAYING;
         end
         PLAYING: begin
            if (invaders_landed) begin
               state_d = GAME_OVER;
               won_d   = 1'b0;
               lives_d = '0;
            end else if (player_hit) begin
               if (lives_q == LIVES_ONE) begin
                  state_d = GAME_OVER;
                  won_d   = 1'b0;
                  lives_d = '0;
               end else begin
                  state_d = LIFE_LOST;
                  lives_d = lives_q - LIVES_ONE;
               end
            end else if (wave_cleared) begin
               if (level_q == LEVEL_LAST) begin
                  state_d = GAME_OVER;
                  won_d   = 1'b1;
               end else begin
                  state_d = LEVEL_CLEAR;
               end
            end else if (pause_e) begin
               state_d = PAUSED;
            end
         end
         PAUSED: begin
            // Abort outranks resume when both buttons rise together.
            if (start_e) begin
               state_d = IDLE;
            end else if (pause_e) begin
               state_d = PLAYING;
            end
         end
         LIFE_LOST: begin
            if (cnt_q == RESPAWN_LAST) begin
               state_d       = PLAYING;
               level_start_d = 1'b1;
            end
         end
         LEVEL_CLEAR: begin
            if (cnt_q == CLEAR_LAST) begin
               state_d       = PLAYING;
               level_d       = level_q + LEVEL_W'(1);
               level_start_d = 1'b1;
            end
         end
         GAME_OVER: begin
            if (start_e) state_d = START;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every new game is initialised on the edge that enters START.
      if (state_d == START) begin
         start_pulse_d = 1'b1;
         level_start_d = 1'b1;
         lives_d       = LIVES_INIT;
         level_d       = '0;
         won_d         = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == LIFE_LOST) || (state_q == LEVEL_CLEAR)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         lives_q       <= '0;
         level_q       <= '0;
         cnt_q         <= '0;
         won_q         <= 1'b0;
         start_pulse_q <= 1'b0;
         level_start_q <= 1'b0;
         is_playing_q  <= 1'b0;
         is_paused_q   <= 1'b0;
         is_finished_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         level_q       <= level_d;
         cnt_q         <= cnt_d;
         won_q         <= won_d;
         start_pulse_q <= start_pulse_d;
         level_start_q <= level_start_d;
         is_playing_q  <= (state_d == PLAYING);
         is_paused_q   <= (state_d == PAUSED);
         is_finished_q <= (state_d == GAME_OVER);
      end
   end

   assign state_o     = state_q;
   assign start_pulse = start_pulse_q;
   assign level_start = level_start_q;
   assign is_playing  = is_playing_q;
   assign is_paused   = is_paused_q;
   assign is_finished = is_finished_q;
   assign won         = won_q;
   assign lives       = lives_q;
   assign level       = level_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb/tb_game_ctrl_fsm.sv - directed and randomized checks of game_ctrl_fsm against a reference model
module tb_game_ctrl_fsm;
   import game_pkg::*;

   localparam int NL = 3;
   localparam int NV = 2;
   localparam int RC = 4;
   localparam int CC = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_btn = 1'b0;
   logic        pause_btn = 1'b0;
   logic        player_hit = 1'b0;
   logic        wave_cleared = 1'b0;
   logic        invaders_landed = 1'b0;
   game_state_t state_o;
   logic        start_pulse, level_start, is_playing, is_paused, is_finished, won;
   logic [1:0]  lives;
   logic [0:0]  level;

   int checks = 0;
   int failures = 0;

   game_ctrl_fsm #(
      .NUM_LIVES      (NL),
      .NUM_LEVELS     (NV),
      .RESPAWN_CYCLES (RC),
      .CLEAR_CYCLES   (CC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start_btn       (start_btn),
      .pause_btn       (pause_btn),
      .player_hit      (player_hit),
      .wave_cleared    (wave_cleared),
      .invaders_landed (invaders_landed),
      .state_o         (state_o),
      .start_pulse     (start_pulse),
      .level_start     (level_start),
      .is_playing      (is_playing),
      .is_paused       (is_paused),
      .is_finished     (is_finished),
      .won             (won),
      .lives           (lives),
      .level           (level)
   );

   always #5 clk = ~clk;

   // Reference model: game mode plus a remaining-cycles timer for the waits.
   game_state_t m_state = IDLE;
   int          m_lives = 0;
   int          m_level = 0;
   int          m_left = 0;
   bit          m_won = 1'b0;
   bit          m_sp = 1'b0;
   bit          m_ls = 1'b0;
   bit          m_prev_s = 1'b0;
   bit          m_prev_p = 1'b0;

   task automatic new_game();
      m_state = START;
      m_sp    = 1'b1;
      m_ls    = 1'b1;
      m_lives = NL;
      m_level = 0;
      m_won   = 1'b0;
   endtask

   task automatic model_step();
      bit se, pe;
      se = start_btn && !m_prev_s;
      pe = pause_btn && !m_prev_p;
      m_prev_s = start_btn;
      m_prev_p = pause_btn;
      m_sp = 1'b0;
      m_ls = 1'b0;
      if (reset) begin
         m_state = IDLE;
         m_lives = 0;
         m_level = 0;
         m_won   = 1'b0;
         m_left  = 0;
         return;
      end
      case (m_state)
         IDLE:      if (se) new_game();
         START:     m_state = PLAYING;
         PLAYING: begin
            if (invaders_landed) begin
               m_state = GAME_OVER; m_won = 1'b0; m_lives = 0;
            end else if (player_hit) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) begin
                  m_state = GAME_OVER; m_won = 1'b0;
               end else begin
                  m_state = LIFE_LOST; m_left = RC;
               end
            end else if (wave_cleared) begin
               if (m_level == NV - 1) begin
                  m_state = GAME_OVER; m_won = 1'b1;
               end else begin
                  m_state = LEVEL_CLEAR; m_left = CC;
               end
            end else if (pe) begin
               m_state = PAUSED;
            end
         end
         PAUSED: begin
            if (se) m_state = IDLE;
            else if (pe) m_state = PLAYING;
         end
         LIFE_LOST: begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_state = PLAYING; m_ls = 1'b1;
            end
         end
         LEVEL_CLEAR: begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_state = PLAYING; m_ls = 1'b1; m_level = m_level + 1;
            end
         end
         GAME_OVER: if (se) new_game();
         default:   m_state = IDLE;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("m_state", state_o, m_state);
      chk("m_start_pulse", start_pulse, m_sp);
      chk("m_level_start", level_start, m_ls);
      chk("m_lives", lives, m_lives);
      chk("m_level", level, m_level);
      chk("m_won", won, m_won);
      chk("m_is_playing", is_playing, m_state == PLAYING);
      chk("m_is_paused", is_paused, m_state == PAUSED);
      chk("m_is_finished", is_finished, m_state == GAME_OVER);
   endtask

   task automatic cyc(input bit h, input bit c, input bit l);
      player_hit      = h;
      wave_cleared    = c;
      invaders_landed = l;
      @(posedge clk);
      model_step();
      #1;
      check_model();
      player_hit      = 1'b0;
      wave_cleared    = 1'b0;
      invaders_landed = 1'b0;
   endtask

   task automatic start_game();
      start_btn = 1'b0;
      cyc(0, 0, 0);
      start_btn = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      start_btn = 1'b0;
   endtask

   task automatic wait_playing(output int n);
      n = 0;
      while (!is_playing && n < 20) begin
         n++;
         cyc(0, 0, 0);
      end
   endtask

   initial begin
      int n;

      reset = 1'b1;
      cyc(0, 0, 0);
      chk("reset_state", state_o, IDLE);
      chk("reset_lives", lives, 0);
      chk("reset_won", won, 0);
      reset = 1'b0;
      cyc(0, 0, 0);

      start_btn = 1'b1;
      cyc(0, 0, 0);
      chk("start_pulse", start_pulse, 1);
      chk("start_level_start", level_start, 1);
      chk("start_lives", lives, NL);
      chk("start_level", level, 0);
      cyc(0, 0, 0);
      chk("start_playing", is_playing, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0);
         chk("held_start_no_restart", start_pulse, 0);
      end
      start_btn = 1'b0;

      for (int i = 0; i < NL; i++) begin
         cyc(1, 0, 0);
         if (i < NL - 1) begin
            chk("hit_lives", lives, NL - 1 - i);
            wait_playing(n);
            chk("respawn_len", n, RC);
         end else begin
            chk("last_hit_state", state_o, GAME_OVER);
            chk("last_hit_won", won, 0);
            chk("last_hit_lives", lives, 0);
         end
      end

      start_game();
      cyc(0, 1, 0);
      chk("clear_state", state_o, LEVEL_CLEAR);
      wait_playing(n);
      chk("clear_len", n, CC);
      chk("clear_level", level, 1);
      chk("clear_level_start", level_start, 1);
      cyc(0, 1, 0);
      chk("win_state", state_o, GAME_OVER);
      chk("win_won", won, 1);

      start_game();
      cyc(1, 1, 0);
      chk("prio_state", state_o, LIFE_LOST);
      chk("prio_lives", lives, 2);
      chk("prio_level", level, 0);
      wait_playing(n);
      cyc(0, 0, 1);
      start_game();
      cyc(0, 0, 1);
      chk("landed_state", state_o, GAME_OVER);
      chk("landed_lives", lives, 0);

      start_game();
      pause_btn = 1'b1;
      cyc(0, 0, 0);
      chk("pause_state", state_o, PAUSED);
      cyc(1, 1, 1);
      chk("pause_hit_ignored", lives, NL);
      pause_btn = 1'b0;
      cyc(0, 0, 0);
      pause_btn = 1'b1;
      cyc(0, 0, 0);
      chk("resume_state", state_o, PLAYING);
      pause_btn = 1'b0;
      cyc(0, 0, 0);
      pause_btn = 1'b1;
      cyc(0, 0, 0);
      pause_btn = 1'b0;
      start_btn = 1'b1;
      cyc(0, 0, 0);
      chk("abort_state", state_o, IDLE);
      chk("abort_lives_hold", lives, NL);
      start_btn = 1'b0;

      start_game();
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      reset = 1'b1;
      cyc(0, 0, 0);
      chk("midclear_reset_state", state_o, IDLE);
      chk("midclear_reset_level", level, 0);
      chk("midclear_reset_lives", lives, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0);
         chk("midclear_no_level_start", level_start, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
         if ($urandom_range(0, 7) == 0)  pause_btn = ~pause_btn;
         reset = ($urandom_range(0, 199) == 0);
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 39) == 0);
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
